// File: rtl/sync_updown_counter.sv
// Synchronous up/down counter with programmable modulus, clear/load, wrap or saturate,
// terminal-count flag, one-cycle wrap pulse and sticky overflow flag.
module sync_updown_counter #(
  parameter int unsigned SIZE      = 4,
  parameter int unsigned MODULUS   = 16,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            mode,
  input  logic            sat,
  input  logic            clr,
  input  logic            load,
  input  logic [SIZE-1:0] d,
  output logic [SIZE-1:0] q,
  output logic [SIZE-1:0] qbar,
  output logic            tc,
  output logic            wrap,
  output logic            ovf
);

  // One extra bit so MODULUS == 2**SIZE stays representable in compares.
  localparam int unsigned     W       = SIZE + 1;
  localparam longint unsigned MOD_L   = 64'(MODULUS);
  localparam longint unsigned LIMIT_L = 64'd1 << SIZE;
  localparam logic [W-1:0]    MOD_W   = W'(MODULUS);
  localparam logic [W-1:0]    TOP_W   = W'(MODULUS - 1);
  localparam logic [SIZE-1:0] TOP_Q   = SIZE'(MODULUS - 1);
  localparam logic [SIZE-1:0] RST_Q   = SIZE'(RESET_VAL);

  if (MODULUS < 2 || MOD_L > LIMIT_L || RESET_VAL >= MODULUS) begin : g_bad_params
    $error("sync_updown_counter: illegal SIZE/MODULUS/RESET_VAL combination");
  end

  logic [W-1:0]    q_ext;
  logic [W-1:0]    d_ext;
  logic            at_top;
  logic            at_zero;
  logic [SIZE-1:0] q_nxt;
  logic            wrap_nxt;
  logic            ovf_nxt;

  assign q_ext   = {1'b0, q};
  assign d_ext   = {1'b0, d};
  assign at_top  = (q_ext == TOP_W);
  assign at_zero = (q_ext == W'(0));

  // Next state: clr > load > en.
  always_comb begin
    q_nxt    = q;
    wrap_nxt = 1'b0;
    ovf_nxt  = ovf;
    if (clr) begin
      q_nxt   = '0;
      ovf_nxt = 1'b0;
    end else if (load) begin
      q_nxt = (d_ext < MOD_W) ? d : TOP_Q;
    end else if (en) begin
      if (mode) begin
        if (!at_top) begin
          q_nxt = SIZE'(q_ext + W'(1));
        end else begin
          ovf_nxt = 1'b1;
          if (!sat) begin
            q_nxt    = '0;
            wrap_nxt = 1'b1;
          end
        end
      end else begin
        if (!at_zero) begin
          q_nxt = SIZE'(q_ext - W'(1));
        end else begin
          ovf_nxt = 1'b1;
          if (!sat) begin
            q_nxt    = TOP_Q;
            wrap_nxt = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q    <= RST_Q;
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      q    <= q_nxt;
      wrap <= wrap_nxt;
      ovf  <= ovf_nxt;
    end
  end

  assign qbar = ~q;
  assign tc   = mode ? at_top : at_zero;

endmodule

// File: tb/tb_sync_updown_counter.sv
// Scoreboard bench for sync_updown_counter: directed steps push expected values,
// a monitor pops and compares after each edge (or on an explicit sample request).
module tb_sync_updown_counter;

  typedef struct {
    int         sel;
    logic [3:0] q;
    logic       wrap;
    logic       ovf;
    logic       tc;
    string      name;
  } exp_t;

  logic clk, rst, en, mode, sat, clr, load, smp;
  logic [3:0] d;

  logic [3:0] q10, qb10, q16, qb16;
  logic [0:0] q2, qb2;
  logic tc10, wr10, ov10, tc16, wr16, ov16, tc2, wr2, ov2;

  exp_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  sync_updown_counter #(.SIZE(4), .MODULUS(10), .RESET_VAL(0)) dut10 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sat(sat), .clr(clr), .load(load),
    .d(d), .q(q10), .qbar(qb10), .tc(tc10), .wrap(wr10), .ovf(ov10));

  sync_updown_counter #(.SIZE(4), .MODULUS(16), .RESET_VAL(3)) dut16 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sat(sat), .clr(clr), .load(load),
    .d(d), .q(q16), .qbar(qb16), .tc(tc16), .wrap(wr16), .ovf(ov16));

  sync_updown_counter #(.SIZE(1), .MODULUS(2), .RESET_VAL(0)) dut2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sat(sat), .clr(clr), .load(load),
    .d(d[0:0]), .q(q2), .qbar(qb2), .tc(tc2), .wrap(wr2), .ovf(ov2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, pending=%0d", exp_q.size());
    $fatal(1, "watchdog expired");
  end

  // Monitor: compare the selected DUT 1 time unit after each edge or sample request.
  initial begin
    exp_t e;
    logic [3:0] aq, aqb, mask, eqb;
    logic aw, ao, at;
    forever begin
      @(posedge clk or posedge smp);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        case (e.sel)
          0:       begin aq = q10; aqb = qb10; aw = wr10; ao = ov10; at = tc10; mask = 4'hF; end
          1:       begin aq = q16; aqb = qb16; aw = wr16; ao = ov16; at = tc16; mask = 4'hF; end
          default: begin aq = {3'b0, q2}; aqb = {3'b0, qb2}; aw = wr2; ao = ov2; at = tc2; mask = 4'h1; end
        endcase
        eqb = ~e.q & mask;
        checks++;
        if (aq !== e.q || aqb !== eqb || aw !== e.wrap || ao !== e.ovf || at !== e.tc) begin
          failures++;
          $display("FAIL %s (dut %0d): got q=%0d qbar=%h wrap=%b ovf=%b tc=%b, want q=%0d qbar=%h wrap=%b ovf=%b tc=%b",
                   e.name, e.sel, aq, aqb, aw, ao, at, e.q, eqb, e.wrap, e.ovf, e.tc);
        end
      end
    end
  end

  task automatic push(input int sel, input logic [3:0] eq, input logic ew, input logic eo,
                      input logic et, input string nm);
    exp_t e;
    e.sel = sel; e.q = eq; e.wrap = ew; e.ovf = eo; e.tc = et; e.name = nm;
    exp_q.push_back(e);
  endtask

  // Drive inputs at negedge; expectation applies after the following rising edge.
  task automatic step(input int sel, input logic i_en, input logic i_mode, input logic i_sat,
                      input logic i_clr, input logic i_load, input logic [3:0] i_d,
                      input logic [3:0] eq, input logic ew, input logic eo, input logic et,
                      input string nm);
    @(negedge clk);
    en = i_en; mode = i_mode; sat = i_sat; clr = i_clr; load = i_load; d = i_d;
    push(sel, eq, ew, eo, et, nm);
  endtask

  // Immediate sample between clock edges.
  task automatic expect_now(input int sel, input logic [3:0] eq, input logic ew, input logic eo,
                            input logic et, input string nm);
    push(sel, eq, ew, eo, et, nm);
    smp = 1'b1;
    #2;
    smp = 1'b0;
  endtask

  initial begin
    rst = 1'b0; smp = 1'b0;
    en = 1'b0; mode = 1'b1; sat = 1'b0; clr = 1'b0; load = 1'b0; d = 4'd0;

    @(negedge clk); expect_now(0, 4'd0, 1'b0, 1'b0, 1'b0, "reset_m10");
    @(negedge clk); expect_now(1, 4'd3, 1'b0, 1'b0, 1'b0, "reset_m16");
    @(negedge clk); expect_now(2, 4'd0, 1'b0, 1'b0, 1'b0, "reset_m2");
    @(negedge clk); rst = 1'b1;

    // MODULUS=10 up count and wrap
    step(0, 0, 1, 0, 0, 0, 4'd0, 4'd0, 0, 0, 0, "idle_first_edge");
    for (int k = 1; k <= 9; k++)
      step(0, 1, 1, 0, 0, 0, 4'd0, 4'(k), 0, 0, (k == 9), "up_count");
    step(0, 1, 1, 0, 0, 0, 4'd0, 4'd0, 1, 1, 0, "up_wrap");
    step(0, 1, 1, 0, 0, 0, 4'd0, 4'd1, 0, 1, 0, "wrap_one_cycle");

    // Down wrap from 0
    step(0, 0, 0, 0, 1, 0, 4'd0, 4'd0, 0, 0, 1, "clr_to_zero");
    step(0, 1, 0, 0, 0, 0, 4'd0, 4'd9, 1, 1, 0, "dn_wrap");
    step(0, 1, 0, 0, 0, 0, 4'd0, 4'd8, 0, 1, 0, "dn_after_wrap");

    // Saturate up at 9, then clear
    step(0, 0, 1, 1, 0, 1, 4'd9, 4'd9, 0, 1, 1, "load9");
    for (int k = 0; k < 3; k++)
      step(0, 1, 1, 1, 0, 0, 4'd0, 4'd9, 0, 1, 1, "sat_up");
    step(0, 0, 1, 1, 1, 0, 4'd0, 4'd0, 0, 0, 0, "clr_after_sat");

    // Load clamp and priority
    step(0, 0, 1, 0, 0, 1, 4'd12, 4'd9, 0, 0, 1, "load_clamp");
    step(0, 1, 1, 0, 0, 1, 4'd5,  4'd5, 0, 0, 0, "load_beats_en");
    step(0, 0, 1, 0, 0, 1, 4'd15, 4'd9, 0, 0, 1, "load_clamp_max");
    step(0, 1, 1, 0, 1, 1, 4'd7,  4'd0, 0, 0, 0, "clr_beats_load");
    for (int k = 0; k < 5; k++)
      step(0, 0, 1'(k % 2), 0, 0, 0, 4'd0, 4'd0, 0, 0, ~1'(k % 2), "hold_tc_mode");
    step(0, 1, 0, 1, 0, 0, 4'd0, 4'd0, 0, 1, 1, "sat_dn");
    step(0, 0, 0, 1, 0, 0, 4'd0, 4'd0, 0, 1, 1, "ovf_sticky");

    // MODULUS=2 repeated wraps
    step(2, 0, 1, 0, 1, 0, 4'd0, 4'd0, 0, 0, 0, "m2_clr");
    step(2, 1, 1, 0, 0, 0, 4'd0, 4'd1, 0, 0, 1, "m2_up1");
    step(2, 1, 1, 0, 0, 0, 4'd0, 4'd0, 1, 1, 0, "m2_wrap_a");
    step(2, 1, 1, 0, 0, 0, 4'd0, 4'd1, 0, 1, 1, "m2_up2");
    step(2, 1, 1, 0, 0, 0, 4'd0, 4'd0, 1, 1, 0, "m2_wrap_b");
    step(2, 1, 0, 0, 0, 0, 4'd0, 4'd1, 1, 1, 0, "m2_dn_wrap");
    step(2, 1, 0, 0, 0, 0, 4'd0, 4'd0, 0, 1, 1, "m2_dn");

    // MODULUS=16, RESET_VAL=3: full-range wrap, then reset mid-count
    step(1, 0, 1, 0, 1, 0, 4'd0,  4'd0,  0, 0, 0, "m16_clr");
    step(1, 0, 1, 0, 0, 1, 4'd14, 4'd14, 0, 0, 0, "m16_load14");
    step(1, 1, 1, 0, 0, 0, 4'd0,  4'd15, 0, 0, 1, "m16_top");
    step(1, 1, 1, 0, 0, 0, 4'd0,  4'd0,  1, 1, 0, "m16_wrap");
    @(negedge clk);
    #1 rst = 1'b0;
    expect_now(1, 4'd3, 0, 0, 0, "m16_async_reset");
    rst = 1'b1;
    push(1, 4'd4, 0, 0, 0, "m16_resume");
    step(1, 1, 1, 0, 0, 0, 4'd0, 4'd5, 0, 0, 0, "m16_count");

    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_updown_counter.md
# sync_updown_counter

Parametrised synchronous up/down counter, the successor to the ripple JK counter. All state bits share one clock edge, so no ripple settling is required. Adds a programmable modulus, count enable, synchronous clear and parallel load, wrap or saturate mode, a terminal-count flag, a wrap pulse and a sticky overflow flag. Used as the general-purpose event and period counter in the datapath and timing blocks.

## Interface
- SIZE, 4, counter width in bits (≥1)
- MODULUS, 16, count range 0..MODULUS-1; legal 2..2**SIZE
- RESET_VAL, 0, value of q after reset; must be < MODULUS
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  reset, asynchronous assert, active-low (0 = reset)
- en  input  1  count enable; 1 = step on this edge
- mode  input  1  direction; 1 = up, 0 = down
- sat  input  1  limit behaviour; 1 = saturate at range end, 0 = wrap
- clr  input  1  synchronous clear to 0 and clear ovf
- load  input  1  synchronous parallel load of d
- d  input  SIZE  load value
- q  output  SIZE  count value (registered)
- qbar  output  SIZE  bitwise ~q
- tc  output  1  terminal count, combinational: (mode && q==MODULUS-1) || (!mode && q==0)
- wrap  output  1  registered one-cycle pulse, high in the cycle after a wrap edge
- ovf  output  1  sticky overflow/underflow flag (registered)

## Operation
- Reset (rst=0, any time, independent of clk): q=RESET_VAL, qbar=~RESET_VAL, wrap=0, ovf=0. All outputs are held while rst=0. tc follows q.
- Per rising clk edge with rst=1, the priority is clr > load > en. Inputs are don't-care when not selected.
- clr=1: q←0, ovf←0, wrap←0.
- load=1 (clr=0): q←d if d<MODULUS, else q←MODULUS-1 (clamp). wrap←0. ovf unchanged.
- en=1, mode=1:
  - q<MODULUS-1: q←q+1.
  - q=MODULUS-1, sat=0: q←0, wrap←1, ovf←1.
  - q=MODULUS-1, sat=1: q holds, wrap←0, ovf←1.
- en=1, mode=0:
  - q>0: q←q-1.
  - q=0, sat=0: q←MODULUS-1, wrap←1, ovf←1.
  - q=0, sat=1: q holds, wrap←0, ovf←1.
- en=0 (no clr/load): q holds, wrap←0, ovf holds.
- Arithmetic: compare and increment are done SIZE+1 bits wide so MODULUS=2**SIZE does not alias. q is never outside 0..MODULUS-1.
- mode or sat may change on any cycle. They take effect on the next edge, with no pipeline state.
- Parameter checks: elaboration fails if MODULUS<2, MODULUS>2**SIZE or RESET_VAL≥MODULUS.

## Timing
- q, wrap and ovf update 1 cycle after the qualifying edge. qbar is combinational from q.
- tc is combinational from q and mode, with zero latency. An external cascade uses en_next = en & tc.
- wrap is high for exactly one cycle per wrap event. Back-to-back wraps (MODULUS=2, en held) give wrap=1 every cycle the edge wraps.
- Reset deassertion is synchronised externally. The counter does not step on the first edge unless en, clr or load is asserted.
- Reset asserted mid-count: q returns to RESET_VAL within the same cycle. No stale wrap pulse appears after release.

## Test plan
- MODULUS=10, reset, en=1, mode=1, sat=0 for 10 edges: q steps 0→9, tc=1 at q=9. The 10th edge gives q=0, wrap=1 for one cycle, ovf=1.
- MODULUS=10, q=0, mode=0, sat=0, one en edge: q=9, wrap=1, ovf=1. A second edge gives q=8, wrap=0, ovf still 1.
- MODULUS=10, q=9, mode=1, sat=1, 3 en edges: q stays 9, wrap stays 0, ovf=1. Then clr=1 gives q=0, ovf=0.
- SIZE=4, MODULUS=10, load=1 with d=12: q=9. load=1 with d=5 and en=1 on the same edge: q=5 (load beats count).
- clr=1 and load=1 (d=7) on the same edge: q=0. en=0 for 5 edges: q holds and tc tracks mode.
- MODULUS=16, RESET_VAL=3, counting up, rst pulsed low between edges: q=3 immediately, qbar=4'b1100, ovf=0. Count resumes 3→4 after release.
